// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch-to-decode instruction assembler.
// Holds the assembler state enum, length-width derivation and bubble counter width.
package pipe_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_e;

    localparam int BUBBLE_CNT_W = 16;

    // Wide all-zero pattern; users slice it down to their own instruction width.
    localparam int IR_MAX_W = 1024;
    localparam logic [IR_MAX_W-1:0] IR_ZERO = '0;

    function automatic int len_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage

// File: rtl/ir_word_buffer.sv
// Indexed word-slot register file for a partially assembled instruction.
// clr zeroes every slot; a write in the same cycle lands on top of the clear.
module ir_word_buffer
    import pipe_pkg::*;
#(
    parameter int WW        = 8,
    parameter int MAX_BYTES = 2,
    parameter int IDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [WW-1:0]           wr_word,
    output logic [WW*MAX_BYTES-1:0] slots
);

    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_slot
            logic [WW-1:0] slot_q;
            logic [WW-1:0] slot_d;

            always_comb begin
                slot_d = slot_q;
                if (clr) begin
                    slot_d = IR_ZERO[WW-1:0];
                end
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    slot_d = wr_word;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slots[gi*WW +: WW] = slot_q;
        end
    endgenerate

endmodule

// File: rtl/ir_assembler_reg.sv
// Assembles 1..MAX_BYTES fetch words into one tagged instruction for decode.
// Optional build macro IR_BUBBLE_CNT_EN adds a saturating decode-bubble counter output.
module ir_assembler_reg
    import pipe_pkg::*;
#(
    parameter int WW        = 8,
    parameter int MAX_BYTES = 2,
    parameter int PC_W      = 8,
    parameter int LEN_W     = len_width(MAX_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    stall,
    input  logic                    f_valid,
    input  logic [WW-1:0]           f_word,
    input  logic [PC_W-1:0]         f_pc,
    input  logic [LEN_W-1:0]        f_len,
    output logic                    f_ready,
    output logic [WW*MAX_BYTES-1:0] ir,
    output logic [PC_W-1:0]         ir_pc,
    output logic [LEN_W-1:0]        ir_len,
    output logic                    ir_valid,
    output logic                    sf
`ifdef IR_BUBBLE_CNT_EN
    ,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

    localparam int IR_W = WW * MAX_BYTES;

    asm_state_e       state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [PC_W-1:0]  ir_pc_q, ir_pc_d;
    logic [LEN_W-1:0] ir_len_q, ir_len_d;
    logic             ir_valid_q, ir_valid_d;
    logic             sf_q, sf_d;

    logic             accept;
    logic             complete;
    logic             buf_clr;
    logic             buf_wr;
    logic [LEN_W-1:0] f_len_eff;
    logic [IR_W-1:0]  buf_slots;
    logic [IR_W-1:0]  assembled;

    assign f_ready = !stall || !ir_valid_q;
    assign accept  = f_valid && f_ready && !flush;

    // Zero means one word; anything beyond the slot count is clamped to it.
    always_comb begin
        f_len_eff = f_len;
        if (f_len == '0) begin
            f_len_eff = LEN_W'(1);
        end else if (f_len > LEN_W'(MAX_BYTES)) begin
            f_len_eff = LEN_W'(MAX_BYTES);
        end
    end

    always_comb begin
        complete = 1'b0;
        if (accept) begin
            if (state_q == IDLE) begin
                complete = (f_len_eff == LEN_W'(1));
            end else begin
                complete = ((idx_q + LEN_W'(1)) == len_q);
            end
        end
    end

    ir_word_buffer #(
        .WW        (WW),
        .MAX_BYTES (MAX_BYTES),
        .IDX_W     (LEN_W)
    ) u_word_buffer (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_idx  (idx_q),
        .wr_word (f_word),
        .slots   (buf_slots)
    );

    // Completed instruction: stored slots below idx, the live word at idx, zeros above.
    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_asm
            assign assembled[gi*WW +: WW] =
                (LEN_W'(gi) < idx_q)                  ? buf_slots[gi*WW +: WW] :
                ((LEN_W'(gi) == idx_q) && accept)     ? f_word :
                                                        IR_ZERO[WW-1:0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_len_d   = ir_len_q;
        ir_valid_d = ir_valid_q;
        sf_d       = sf_q;
        buf_clr    = 1'b0;
        buf_wr     = 1'b0;

        if (flush) begin
            state_d    = IDLE;
            idx_d      = '0;
            sf_d       = 1'b0;
            ir_valid_d = 1'b0;
            ir_d       = IR_ZERO[IR_W-1:0];
            ir_len_d   = '0;
            buf_clr    = 1'b1;
        end else begin
            if (ir_valid_q && !stall) begin
                ir_valid_d = 1'b0;
            end
            if (accept) begin
                buf_wr = 1'b1;
                if (state_q == IDLE) begin
                    buf_clr = 1'b1;
                    pc_d    = f_pc;
                    len_d   = f_len_eff;
                end
                if (complete) begin
                    ir_d       = assembled;
                    ir_pc_d    = (state_q == IDLE) ? f_pc : pc_q;
                    ir_len_d   = (state_q == IDLE) ? f_len_eff : len_q;
                    ir_valid_d = 1'b1;
                    state_d    = IDLE;
                    idx_d      = '0;
                    sf_d       = 1'b0;
                end else begin
                    state_d = COLLECT;
                    idx_d   = idx_q + LEN_W'(1);
                    sf_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_len_q   <= '0;
            ir_valid_q <= 1'b0;
            sf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_len_q   <= ir_len_d;
            ir_valid_q <= ir_valid_d;
            sf_q       <= sf_d;
        end
    end

    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_len   = ir_len_q;
    assign ir_valid = ir_valid_q;
    assign sf       = sf_q;

`ifdef IR_BUBBLE_CNT_EN
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic                    bubble_evt;

    // A lost instruction on flush, or a decode slot that goes unused.
    assign bubble_evt = (flush && (ir_valid_q || (state_q == COLLECT))) ||
                        (!stall && !ir_valid_q);

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_evt && (bubble_cnt_q != {BUBBLE_CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ir_assembler_reg.sv
// Randomised and directed check of ir_assembler_reg against a queue-based model
// of instruction assembly; one line is printed per completed instruction.
module tb_ir_assembler_reg;

    localparam int WW        = 8;
    localparam int MAX_BYTES = 2;
    localparam int PC_W      = 8;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int IR_W      = WW * MAX_BYTES;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             stall = 1'b0;
    logic             f_valid = 1'b0;
    logic [WW-1:0]    f_word = '0;
    logic [PC_W-1:0]  f_pc = '0;
    logic [LEN_W-1:0] f_len = '0;
    logic             f_ready;
    logic [IR_W-1:0]  ir;
    logic [PC_W-1:0]  ir_pc;
    logic [LEN_W-1:0] ir_len;
    logic             ir_valid;
    logic             sf;
`ifdef IR_BUBBLE_CNT_EN
    logic [15:0]      bubble_cnt;
`endif

    always #5 clk = ~clk;

    ir_assembler_reg #(
        .WW        (WW),
        .MAX_BYTES (MAX_BYTES),
        .PC_W      (PC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall    (stall),
        .f_valid  (f_valid),
        .f_word   (f_word),
        .f_pc     (f_pc),
        .f_len    (f_len),
        .f_ready  (f_ready),
        .ir       (ir),
        .ir_pc    (ir_pc),
        .ir_len   (ir_len),
        .ir_valid (ir_valid),
        .sf       (sf)
`ifdef IR_BUBBLE_CNT_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words of the instruction being gathered, plus the decode-side view.
    logic [WW-1:0]   m_words[$];
    int              m_target;
    logic [PC_W-1:0] m_pc0;
    logic [IR_W-1:0] m_ir;
    logic [PC_W-1:0] m_ir_pc;
    int              m_ir_len;
    bit              m_valid;
    int unsigned     m_bub;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_target = 0;
        m_pc0    = '0;
        m_ir     = '0;
        m_ir_pc  = '0;
        m_ir_len = 0;
        m_valid  = 1'b0;
        m_bub    = 0;
    endtask

    task automatic model_step();
        bit rdy;
        bit acc;
        bit done;
        rdy  = !stall || !m_valid;
        acc  = f_valid && rdy && !flush;
        done = 1'b0;
        if ((flush && (m_valid || m_words.size() > 0)) || (!stall && !m_valid)) begin
            if (m_bub < 65535) m_bub++;
        end
        if (flush) begin
            m_words.delete();
            m_valid  = 1'b0;
            m_ir     = '0;
            m_ir_len = 0;
        end else begin
            if (acc) begin
                if (m_words.size() == 0) begin
                    m_pc0    = f_pc;
                    m_target = (f_len == 0) ? 1 : ((f_len > MAX_BYTES) ? MAX_BYTES : int'(f_len));
                end
                m_words.push_back(f_word);
                if (m_words.size() == m_target) begin
                    m_ir = '0;
                    foreach (m_words[i]) m_ir |= IR_W'(m_words[i]) << (WW * i);
                    m_ir_pc  = m_pc0;
                    m_ir_len = m_target;
                    m_valid  = 1'b1;
                    done     = 1'b1;
                    m_words.delete();
                    $display("txn pc=%h len=%0d ir=%h", m_ir_pc, m_ir_len, m_ir);
                end
            end
            if (!done && m_valid && !stall) m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_eq("ir",       ir,       m_ir);
        check_eq("ir_pc",    ir_pc,    m_ir_pc);
        check_eq("ir_len",   ir_len,   m_ir_len);
        check_eq("ir_valid", ir_valid, m_valid);
        check_eq("sf",       sf,       m_words.size() > 0);
`ifdef IR_BUBBLE_CNT_EN
        check_eq("bubble_cnt", bubble_cnt, m_bub);
`endif
    endtask

    task automatic cycle(input bit s, input bit fl, input bit fv, input logic [WW-1:0] w,
                         input logic [PC_W-1:0] pc, input logic [LEN_W-1:0] ln);
        @(negedge clk);
        check_outputs();
        stall   = s;
        flush   = fl;
        f_valid = fv;
        f_word  = w;
        f_pc    = pc;
        f_len   = ln;
        #1;
        check_eq("f_ready", f_ready, !s || !m_valid);
        model_step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single word, then two-word instruction.
        cycle(0, 0, 1, 8'hA5, 8'h10, 2'd1);
        cycle(0, 0, 1, 8'h3C, 8'h20, 2'd2);
        cycle(0, 0, 1, 8'h7E, 8'h21, 2'd0);
        // Stall while the result is valid: nothing enters, then release.
        repeat (3) cycle(1, 0, 1, 8'h55, 8'h40, 2'd1);
        cycle(0, 0, 1, 8'h55, 8'h40, 2'd1);
        cycle(0, 0, 0, 8'h00, 8'h00, 2'd0);
        // Flush mid-assembly drops the word presented with it.
        cycle(0, 0, 1, 8'h99, 8'h50, 2'd2);
        cycle(0, 1, 1, 8'hDD, 8'h51, 2'd0);
        cycle(0, 0, 0, 8'h00, 8'h00, 2'd0);
        // Flush together with stall over a valid result.
        cycle(0, 0, 1, 8'h12, 8'h60, 2'd1);
        cycle(1, 1, 1, 8'h34, 8'h61, 2'd1);
        cycle(0, 0, 0, 8'h00, 8'h00, 2'd0);
        // Over-long length clamps; zero length means one word.
        cycle(0, 0, 1, 8'hAB, 8'h70, 2'd3);
        cycle(0, 0, 1, 8'hCD, 8'h71, 2'd1);
        cycle(0, 0, 1, 8'hEF, 8'h72, 2'd0);
        // Asynchronous reset in the middle of a two-word assembly.
        cycle(0, 0, 1, 8'h3C, 8'h80, 2'd2);
        @(negedge clk);
        check_outputs();
        f_valid = 1'b0;
        rst     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        cycle(0, 0, 1, 8'h11, 8'h90, 2'd2);
        cycle(0, 0, 1, 8'h22, 8'h91, 2'd2);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
                  WW'($urandom), PC_W'($urandom), LEN_W'($urandom_range(0, 3)));
        end

        @(negedge clk);
        check_outputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
